// File: rtl/sync_fifo_flags_if.sv
// Handshake/status bundle for sync_fifo_flags: the producer/consumer side drives
// through master, the FIFO itself attaches through slave.
interface sync_fifo_flags_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
);
  logic             sclr;
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             wfull;
  logic             rempty;
  logic             almost_full;
  logic             almost_empty;
  logic [ASIZE:0]   count;
  logic             overflow;
  logic             underflow;

  modport master (
    output sclr, wdata, winc, rinc,
    input  rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  sclr, wdata, winc, rinc,
    output rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered full/empty/almost flags, occupancy count and
// sticky overflow/underflow. Define FIFO_FWFT_EN for first-word-fall-through rdata.
module sync_fifo_flags #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int AF_LEVEL = 2**ASIZE-2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  sync_fifo_flags_if.slave  bus
);
  localparam int             DEPTH  = 2**ASIZE;
  localparam logic [ASIZE:0] AF_LVL = AF_LEVEL[ASIZE:0];
  localparam logic [ASIZE:0] AE_LVL = AE_LEVEL[ASIZE:0];
  localparam logic [ASIZE:0] ONE    = {{ASIZE{1'b0}}, 1'b1};

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr, rptr, wptr_nxt, rptr_nxt, count_nxt;
  logic             wr_ok, rd_ok;

  // Acceptance uses the registered flags, so full+read still pops and
  // empty+write still pushes on the same edge.
  always_comb begin
    wr_ok     = bus.winc & ~bus.wfull;
    rd_ok     = bus.rinc & ~bus.rempty;
    wptr_nxt  = wr_ok ? wptr + ONE : wptr;
    rptr_nxt  = rd_ok ? rptr + ONE : rptr;
    count_nxt = bus.count;
    if (wr_ok && !rd_ok) count_nxt = bus.count + ONE;
    if (rd_ok && !wr_ok) count_nxt = bus.count - ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr             <= '0;
      rptr             <= '0;
      bus.count        <= '0;
      bus.wfull        <= 1'b0;
      bus.rempty       <= 1'b1;
      bus.almost_full  <= 1'b0;
      bus.almost_empty <= 1'b1;
      bus.overflow     <= 1'b0;
      bus.underflow    <= 1'b0;
    end else if (bus.sclr) begin
      wptr             <= '0;
      rptr             <= '0;
      bus.count        <= '0;
      bus.wfull        <= 1'b0;
      bus.rempty       <= 1'b1;
      bus.almost_full  <= 1'b0;
      bus.almost_empty <= 1'b1;
      bus.overflow     <= 1'b0;
      bus.underflow    <= 1'b0;
    end else begin
      wptr             <= wptr_nxt;
      rptr             <= rptr_nxt;
      bus.count        <= count_nxt;
      // Extra pointer MSB distinguishes full from empty when low bits match.
      bus.wfull        <= (wptr_nxt[ASIZE] != rptr_nxt[ASIZE]) &&
                          (wptr_nxt[ASIZE-1:0] == rptr_nxt[ASIZE-1:0]);
      bus.rempty       <= (wptr_nxt == rptr_nxt);
      bus.almost_full  <= (count_nxt >= AF_LVL);
      bus.almost_empty <= (count_nxt <= AE_LVL);
      if (bus.winc && bus.wfull)  bus.overflow  <= 1'b1;
      if (bus.rinc && bus.rempty) bus.underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !bus.sclr && wr_ok) mem[wptr[ASIZE-1:0]] <= bus.wdata;
  end

`ifdef FIFO_FWFT_EN
  assign bus.rdata = mem[rptr[ASIZE-1:0]];
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       bus.rdata <= '0;
    else if (!bus.sclr && rd_ok)   bus.rdata <= mem[rptr[ASIZE-1:0]];
  end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomized + directed bench for sync_fifo_flags against a queue-based model
// (DSIZE=8, ASIZE=2, AF_LEVEL=3, AE_LEVEL=1).
module tb_sync_fifo_flags;
  localparam int DSIZE = 8;
  localparam int ASIZE = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  sync_fifo_flags_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus ();

  sync_fifo_flags #(.DSIZE(DSIZE), .ASIZE(ASIZE), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [7:0] q[$];
  bit         m_ovf, m_unf;
  logic [7:0] m_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_rdata = 8'h00;
  endtask

  task automatic model_edge(input bit sclr, input bit winc, input bit rinc, input logic [7:0] wd);
    bit full, empty;
    if (sclr) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    if (winc && full)  m_ovf = 1'b1;
    if (rinc && empty) m_unf = 1'b1;
    if (rinc && !empty) m_rdata = q.pop_front();
    if (winc && !full)  q.push_back(wd);
  endtask

  task automatic check_all(input string ph);
    int n;
    n = q.size();
    chk({ph, ".count"}, 32'(bus.count), n);
    chk({ph, ".wfull"}, 32'(bus.wfull), 32'(n == DEPTH));
    chk({ph, ".rempty"}, 32'(bus.rempty), 32'(n == 0));
    chk({ph, ".afull"}, 32'(bus.almost_full), 32'(n >= AF));
    chk({ph, ".aempty"}, 32'(bus.almost_empty), 32'(n <= AE));
    chk({ph, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
    chk({ph, ".unf"}, 32'(bus.underflow), 32'(m_unf));
`ifdef FIFO_FWFT_EN
    if (n != 0) chk({ph, ".rdata"}, 32'(bus.rdata), 32'(q[0]));
`else
    chk({ph, ".rdata"}, 32'(bus.rdata), 32'(m_rdata));
`endif
  endtask

  // Called #1 after an edge: drive, take the next edge, update model, check.
  task automatic step(input string ph, input bit sclr, input bit winc, input bit rinc,
                      input logic [7:0] wd);
    bus.sclr  = sclr;
    bus.winc  = winc;
    bus.rinc  = rinc;
    bus.wdata = wd;
    @(posedge clk);
    model_edge(sclr, winc, rinc, wd);
    #1;
    check_all(ph);
  endtask

  task automatic async_reset(input string ph);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(ph);
    #1 rst = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    model_reset();
    rst       = 1'b1;
    bus.sclr  = 1'b0;
    bus.winc  = 1'b0;
    bus.rinc  = 1'b0;
    bus.wdata = '0;
    #1;
    check_all("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // fill with four words, then drain in order
    for (int i = 0; i < 4; i++) step("fill", 1'b0, 1'b1, 1'b0, 8'(8'h11 * (i + 1)));
    chk("fill.af_full", 32'(bus.almost_full), 1);
    chk("fill.wfull", 32'(bus.wfull), 1);
    for (int i = 0; i < 4; i++) begin
`ifdef FIFO_FWFT_EN
      chk("drain.head", 32'(bus.rdata), 32'(8'h11 * (i + 1)));
`endif
      step("drain", 1'b0, 1'b0, 1'b1, 8'h00);
`ifndef FIFO_FWFT_EN
      chk("drain.data", 32'(bus.rdata), 32'(8'h11 * (i + 1)));
`endif
    end

    // full with simultaneous write+read
    for (int i = 0; i < 4; i++) step("refill", 1'b0, 1'b1, 1'b0, 8'(8'h11 * (i + 1)));
    step("full_wr_rd", 1'b0, 1'b1, 1'b1, 8'h55);
    chk("full_wr_rd.cnt3", 32'(bus.count), 3);
    chk("full_wr_rd.ovf", 32'(bus.overflow), 1);
`ifdef FIFO_FWFT_EN
    chk("full_wr_rd.next", 32'(bus.rdata), 32'h22);
`else
    step("full_wr_rd.rd", 1'b0, 1'b0, 1'b1, 8'h00);
    chk("full_wr_rd.next", 32'(bus.rdata), 32'h22);
`endif

    // empty with simultaneous write+read
    step("flush", 1'b1, 1'b0, 1'b0, 8'h00);
    step("empty_wr_rd", 1'b0, 1'b1, 1'b1, 8'hA5);
    chk("empty_wr_rd.unf", 32'(bus.underflow), 1);
    chk("empty_wr_rd.cnt1", 32'(bus.count), 1);
    step("empty_wr_rd.rd", 1'b0, 1'b0, 1'b1, 8'h00);
`ifndef FIFO_FWFT_EN
    chk("empty_wr_rd.data", 32'(bus.rdata), 32'hA5);
`endif

    // ten write/read pairs across pointer wrap
    step("wrap.clr", 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step("wrap.wr", 1'b0, 1'b1, 1'b0, 8'(i));
      step("wrap.rd", 1'b0, 1'b0, 1'b1, 8'h00);
`ifndef FIFO_FWFT_EN
      chk("wrap.data", 32'(bus.rdata), i);
`endif
    end
    chk("wrap.ovf", 32'(bus.overflow), 0);
    chk("wrap.unf", 32'(bus.underflow), 0);

    // sclr beats write and clears sticky underflow
    step("sclr.unf", 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) step("sclr.fill", 1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
    step("sclr.go", 1'b1, 1'b1, 1'b0, 8'hEE);
    chk("sclr.cnt0", 32'(bus.count), 0);
    chk("sclr.unf0", 32'(bus.underflow), 0);

    // async reset at count=2, then usable again
    step("rst.w0", 1'b0, 1'b1, 1'b0, 8'h01);
    step("rst.w1", 1'b0, 1'b1, 1'b0, 8'h02);
    bus.winc = 1'b0;
    async_reset("rst.mid");
    step("rst.w77", 1'b0, 1'b1, 1'b0, 8'h77);
`ifdef FIFO_FWFT_EN
    chk("rst.head77", 32'(bus.rdata), 32'h77);
`endif
    step("rst.r77", 1'b0, 1'b0, 1'b1, 8'h00);
`ifndef FIFO_FWFT_EN
    chk("rst.data77", 32'(bus.rdata), 32'h77);
`endif

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        bus.winc = 1'b0;
        bus.rinc = 1'b0;
        async_reset("rnd.rst");
      end else begin
        step("rnd", $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 2) != 0, 8'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
